// File: rtl/rggen_event_detector.sv
// rtl/rggen_event_detector.sv - per-bit glitch filter and edge/level detector feeding set/clear bit fields
module rggen_event_detector #(
  parameter int               WIDTH         = 1,
  parameter int               DETECT_MODE   = 0,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] INITIAL_LEVEL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_enable,
  input  logic [WIDTH-1:0] i_event,
  output logic [WIDTH-1:0] o_filtered,
  output logic [WIDTH-1:0] o_set
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  if (DETECT_MODE < 0 || DETECT_MODE > 3) begin : g_bad_mode
    $error("rggen_event_detector: DETECT_MODE must be 0..3");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("rggen_event_detector: FILTER_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] filtered_q, filtered_d;
  logic [WIDTH-1:0] set_q, set_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // The counter only runs while the sample disagrees with the accepted level,
  // so any return to the old level before CNT_MAX throws the pulse away.
  always_comb begin
    filtered_d = filtered_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_event[i] == filtered_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filtered_d[i] = i_event[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    set_d = '0;
    case (DETECT_MODE)
      0:       set_d = i_enable & filtered_d & ~filtered_q;
      1:       set_d = i_enable & ~filtered_d & filtered_q;
      2:       set_d = i_enable & (filtered_d ^ filtered_q);
      default: set_d = i_enable & filtered_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtered_q <= INITIAL_LEVEL;
      set_q      <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filtered_q <= filtered_d;
      set_q      <= set_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_filtered = filtered_q;
  assign o_set      = set_q;

endmodule
